// File: rtl/neptuno_joy_serial.sv
// Scans two DB9 pads through the 74HC165 chain and merges both select phases into
// active-high Megadrive-style words. Optional two-frame debounce: JOY_DEBOUNCE_EN.
module neptuno_joy_serial #(
    parameter int CLK_DIV = 16,
    parameter int NBITS   = 16,
    parameter int SETTLE  = 4
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       joy_data,
    output logic       joy_clk,
    output logic       joy_load,
    output logic       joy_sel,
    output logic [7:0] joy1,
    output logic [7:0] joy2,
    output logic       joy_valid
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBITS - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SHIFT,
        ST_SETTLE
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic               phaseB_q, phaseB_d;
    logic [NBITS-1:0]   sreg_q, sreg_d;
    logic [11:0]        hi_q, hi_d;
    logic               joyClk_q, joyClk_d;
    logic               joyLoad_q, joyLoad_d;
    logic               joySel_q, joySel_d;
    logic [7:0]         joy1_q, joy1_d;
    logic [7:0]         joy2_q, joy2_d;
    logic               valid_q, valid_d;
`ifdef JOY_DEBOUNCE_EN
    logic [15:0]        cand_q, cand_d;
    logic               candVld_q, candVld_d;
`endif

    logic        tick;
    logic [15:0] newWord;
    logic        unusedBits;

    // Layout {start,C,A,B,right,left,down,up}; A and start come from the sel=0 scan.
    function automatic logic [7:0] mergePort(input logic [5:0] hi, input logic [1:0] lo);
        return {lo[1], hi[5], lo[0], hi[4], hi[3:0]};
    endfunction

    assign tick       = (div_q == DIV_LAST);
    assign newWord    = {mergePort(hi_q[11:6], ~sreg_q[13:12]), mergePort(hi_q[5:0], ~sreg_q[5:4])};
    assign unusedBits = ^{sreg_q[NBITS-1:14], sreg_q[7:6]};

    always_comb begin
        state_d   = state_q;
        div_d     = tick ? '0 : div_q + DIV_W'(1);
        idx_d     = idx_q;
        settle_d  = settle_q;
        phaseB_d  = phaseB_q;
        sreg_d    = sreg_q;
        hi_d      = hi_q;
        joyClk_d  = joyClk_q;
        joyLoad_d = joyLoad_q;
        joySel_d  = joySel_q;
        joy1_d    = joy1_q;
        joy2_d    = joy2_q;
        valid_d   = 1'b0;
`ifdef JOY_DEBOUNCE_EN
        cand_d    = cand_q;
        candVld_d = candVld_q;
`endif
        if (tick) begin
            joyLoad_d = 1'b1;
            case (state_q)
                ST_LOAD: begin
                    joyLoad_d = 1'b0;
                    idx_d     = '0;
                    phaseB_d  = 1'b0;
                    state_d   = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (!phaseB_q) begin
                        sreg_d[idx_q] = joy_data;
                        joyClk_d      = 1'b1;
                        phaseB_d      = 1'b1;
                    end else begin
                        joyClk_d = 1'b0;
                        phaseB_d = 1'b0;
                        if (idx_q == IDX_LAST) begin
                            state_d  = ST_SETTLE;
                            settle_d = '0;
                            joySel_d = ~joySel_q;
                            if (joySel_q) begin
                                hi_d = {~sreg_q[13:8], ~sreg_q[5:0]};
                            end else begin
`ifdef JOY_DEBOUNCE_EN
                                cand_d    = newWord;
                                candVld_d = 1'b1;
                                if (candVld_q && (newWord == cand_q)) begin
                                    joy1_d  = newWord[7:0];
                                    joy2_d  = newWord[15:8];
                                    valid_d = 1'b1;
                                end
`else
                                joy1_d  = newWord[7:0];
                                joy2_d  = newWord[15:8];
                                valid_d = 1'b1;
`endif
                            end
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_SETTLE: begin
                    if (settle_q == SET_LAST) begin
                        state_d = ST_LOAD;
                    end else begin
                        settle_d = settle_q + SET_W'(1);
                    end
                end
                default: state_d = ST_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_LOAD;
            div_q     <= '0;
            idx_q     <= '0;
            settle_q  <= '0;
            phaseB_q  <= 1'b0;
            sreg_q    <= '0;
            hi_q      <= '0;
            joyClk_q  <= 1'b0;
            joyLoad_q <= 1'b1;
            joySel_q  <= 1'b1;
            joy1_q    <= '0;
            joy2_q    <= '0;
            valid_q   <= 1'b0;
`ifdef JOY_DEBOUNCE_EN
            cand_q    <= '0;
            candVld_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            idx_q     <= idx_d;
            settle_q  <= settle_d;
            phaseB_q  <= phaseB_d;
            sreg_q    <= sreg_d;
            hi_q      <= hi_d;
            joyClk_q  <= joyClk_d;
            joyLoad_q <= joyLoad_d;
            joySel_q  <= joySel_d;
            joy1_q    <= joy1_d;
            joy2_q    <= joy2_d;
            valid_q   <= valid_d;
`ifdef JOY_DEBOUNCE_EN
            cand_q    <= cand_d;
            candVld_q <= candVld_d;
`endif
        end
    end

    assign joy_clk   = joyClk_q;
    assign joy_load  = joyLoad_q;
    assign joy_sel   = joySel_q;
    assign joy1      = joy1_q;
    assign joy2      = joy2_q;
    assign joy_valid = valid_q;

endmodule

// File: tb/tb_neptuno_joy_serial.sv
// Bench for neptuno_joy_serial: a 74HC165 pad-chain model feeds per-frame button patterns,
// a scoreboard queue holds expected words and a monitor pops them on every joy_valid.
module tb_neptuno_joy_serial;

    localparam int CLK_DIV = 16;
    localparam int NBITS   = 16;
    localparam int SETTLE  = 4;
    localparam int SCAN    = 1 + 2 * NBITS + SETTLE;
    localparam int FRAME   = 2 * SCAN * CLK_DIV;
    localparam int LATENCY = (2 * SCAN - SETTLE) * CLK_DIV;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        joy_data;
    logic        joy_clk, joy_load, joy_sel, joy_valid;
    logic [7:0]  joy1, joy2;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          sinceReset = 0;
    logic [15:0] patHi = 16'hFFFF;
    logic [15:0] patLo = 16'hFFFF;
    logic [15:0] chain = 16'hFFFF;
    logic [15:0] expQ[$];
    logic [15:0] prevWord = 16'h0000;
    bit          prevSet = 1'b0;

    neptuno_joy_serial #(
        .CLK_DIV(CLK_DIV),
        .NBITS  (NBITS),
        .SETTLE (SETTLE)
    ) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .joy_data (joy_data),
        .joy_clk  (joy_clk),
        .joy_load (joy_load),
        .joy_sel  (joy_sel),
        .joy1     (joy1),
        .joy2     (joy2),
        .joy_valid(joy_valid)
    );

    assign joy_data = chain[0];

    initial begin
        forever #5 clk_sys = ~clk_sys;
    end

    initial begin
        forever begin
            @(posedge clk_sys);
            cyc++;
            if (!reset_n) sinceReset = 0;
            else sinceReset++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Pads are active-low on the chain; each word is {port2, port1}.
    function automatic logic [15:0] refWord(input logic [15:0] hi, input logic [15:0] lo);
        logic [7:0]  h, l;
        logic [15:0] w;
        w = '0;
        for (int p = 0; p < 2; p++) begin
            h = ~hi[p*8 +: 8];
            l = ~lo[p*8 +: 8];
            w[p*8 +: 8] = {l[5], h[5], l[4], h[4], h[3], h[2], h[1], h[0]};
        end
        return w;
    endfunction

    // Sets the chain patterns for the next frame and records what that frame must produce.
    task automatic applyStimulus(input logic [15:0] hi, input logic [15:0] lo);
        logic [15:0] w;
        patHi = hi;
        patLo = lo;
        w = refWord(hi, lo);
`ifdef JOY_DEBOUNCE_EN
        if (prevSet && (w == prevWord)) expQ.push_back(w);
        prevWord = w;
        prevSet  = 1'b1;
`else
        expQ.push_back(w);
`endif
    endtask

    task automatic waitFrameEnd();
        logic prev;
        bit   found;
        prev  = joy_sel;
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk_sys);
            if (joy_sel && !prev) begin
                found = 1'b1;
                break;
            end
            prev = joy_sel;
        end
        checkOutput("frameBoundarySeen", 32'(found), 32'd1);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_joy1"}, 32'(joy1), 32'h00);
        checkOutput({tag, "_joy2"}, 32'(joy2), 32'h00);
        checkOutput({tag, "_valid"}, 32'(joy_valid), 32'd0);
        checkOutput({tag, "_load"}, 32'(joy_load), 32'd1);
        checkOutput({tag, "_clk"}, 32'(joy_clk), 32'd0);
        checkOutput({tag, "_sel"}, 32'(joy_sel), 32'd1);
    endtask

    // 74HC165 chain: parallel load while joy_load is low, shift towards bit 0 on joy_clk rise.
    initial begin : padModel
        logic clkPrev;
        logic loadPrev;
        bit   scanActive;
        int   riseCount;
        clkPrev    = 1'b0;
        loadPrev   = 1'b1;
        scanActive = 1'b0;
        riseCount  = 0;
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                scanActive = 1'b0;
                riseCount  = 0;
            end
            if (!joy_load) begin
                chain = joy_sel ? patHi : patLo;
            end else if (joy_clk && !clkPrev) begin
                chain = {1'b1, chain[15:1]};
                riseCount++;
            end
            if (reset_n && !joy_load && loadPrev) begin
                if (scanActive) checkOutput("clkRisesPerScan", 32'(riseCount), 32'(NBITS));
                scanActive = 1'b1;
                riseCount  = 0;
            end
            clkPrev  = joy_clk;
            loadPrev = joy_load;
        end
    end

    initial begin : monitor
        logic        validPrev;
        bit          firstPending;
        int          lastValidCyc;
        logic [15:0] expWord;
        validPrev    = 1'b0;
        firstPending = 1'b1;
        lastValidCyc = -1;
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                firstPending = 1'b1;
                lastValidCyc = -1;
            end else if (joy_valid) begin
                checkOutput("validSingleCycle", 32'(validPrev), 32'd0);
                checkOutput("validExpected", 32'(expQ.size() > 0), 32'd1);
                if (expQ.size() > 0) begin
                    expWord = expQ.pop_front();
                    checkOutput("joyWord", 32'({joy2, joy1}), 32'(expWord));
                end
`ifndef JOY_DEBOUNCE_EN
                if (firstPending) checkOutput("firstValidLatency", 32'(sinceReset), 32'(LATENCY));
                if (lastValidCyc >= 0) checkOutput("framePeriod", 32'(cyc - lastValidCyc), 32'(FRAME));
`endif
                firstPending = 1'b0;
                lastValidCyc = cyc;
            end
            validPrev = joy_valid;
        end
    end

    initial begin : stimulus
        logic [15:0] tblHi[8];
        logic [15:0] tblLo[8];
        logic        prevClk;
        int          rises;
        bit          loadSeen;

        tblHi = '{16'hFFFF, 16'hFFFF, 16'hFFEE, 16'hF7FF, 16'hFFFE, 16'hFFFF, 16'hFFFE, 16'hFFFE};
        tblLo = '{16'hFFFF, 16'hFFFF, 16'hFFEF, 16'hDFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};

        $display("[TB] reset and directed frames");
        repeat (10) @(posedge clk_sys);
        @(negedge clk_sys);
        checkResetState("reset");
        applyStimulus(tblHi[0], tblLo[0]);
        #1 reset_n = 1'b1;

        for (int f = 1; f < 8; f++) begin
            waitFrameEnd();
            applyStimulus(tblHi[f], tblLo[f]);
        end

        $display("[TB] random frames");
        for (int f = 0; f < 6; f++) begin
            waitFrameEnd();
            applyStimulus(16'($urandom), 16'($urandom));
        end
        for (int f = 0; f < 2; f++) begin
            waitFrameEnd();
            applyStimulus(16'hFFEE, 16'hFFEF);
        end
        waitFrameEnd();

        $display("[TB] reset during shift");
        applyStimulus(16'($urandom), 16'($urandom));
        loadSeen = 1'b0;
        for (int i = 0; i < FRAME && !loadSeen; i++) begin
            @(negedge clk_sys);
            loadSeen = !joy_load;
        end
        checkOutput("loadPulseSeen", 32'(loadSeen), 32'd1);
        rises   = 0;
        prevClk = joy_clk;
        for (int i = 0; i < FRAME && rises < 8; i++) begin
            @(negedge clk_sys);
            if (joy_clk && !prevClk) rises++;
            prevClk = joy_clk;
        end
        checkOutput("bit7Reached", 32'(rises), 32'd8);
        reset_n = 1'b0;
        #1;
        checkResetState("asyncReset");
        expQ.delete();
        prevSet = 1'b0;
        repeat (10) @(posedge clk_sys);
        @(negedge clk_sys);
        checkResetState("resetHold");
        applyStimulus(16'hF7FF, 16'hDFFF);
        #1 reset_n = 1'b1;
        waitFrameEnd();
        applyStimulus(16'hF7FF, 16'hDFFF);
        waitFrameEnd();

        repeat (8) @(negedge clk_sys);
        checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
